// File: rtl/instr_encoder.sv
// Encodes compact instruction commands into RV32I words and writes them sequentially into imem.
// One registered write per word; LI may expand to LUI+ADDI, holding cmd_ready low for the second word.
module instr_encoder #(
    parameter int          ADDR_W    = 10,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [3:0]        i_cmd_op,
    input  logic [4:0]        i_cmd_rd,
    input  logic [4:0]        i_cmd_rs1,
    input  logic [4:0]        i_cmd_rs2,
    input  logic [2:0]        i_cmd_funct3,
    input  logic              i_cmd_alt,
    input  logic [31:0]       i_cmd_imm,
    input  logic              i_cmd_last,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wd,
    output logic [ADDR_W:0]   o_word_count,
    output logic              o_done,
    output logic              o_err_op,
    output logic              o_overflow
);

    localparam logic [ADDR_W-1:0] LP_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   LP_CAP  = (ADDR_W+1)'(1) << ADDR_W;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT2, ST_DONE, ST_FULL} state_t;

    state_t              r_state;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wd;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W:0]     r_word_count;
    logic                r_done;
    logic                r_err_op;
    logic                r_overflow;
    logic [31:0]         r_pend_wd;
    logic                r_pend_last;

    logic [31:0]         w_word0;
    logic [31:0]         w_word1;
    logic [1:0]          w_nwords;
    logic                w_illegal;
    logic [11:0]         w_ishamt;
    logic                w_li_small;
    logic [19:0]         w_li_hi;
    logic [ADDR_W:0]     w_free;
    logic [ADDR_W:0]     w_need;
    logic                w_accept;

    // LUI upper part pre-compensates for the sign extension of the following ADDI.
    assign w_li_hi    = i_cmd_imm[31:12] + {19'd0, i_cmd_imm[11]};
    assign w_li_small = (i_cmd_imm[31:11] == {21{i_cmd_imm[11]}});
    assign w_ishamt   = {1'b0, i_cmd_alt, 5'b0, i_cmd_imm[4:0]};
    assign w_free     = LP_CAP - r_word_count;
    assign w_need     = {{(ADDR_W-1){1'b0}}, w_nwords};
    assign w_accept   = i_cmd_valid & o_cmd_ready;

    always_comb begin
        w_word0   = 32'd0;
        w_word1   = 32'd0;
        w_nwords  = 2'd1;
        w_illegal = 1'b0;
        case (i_cmd_op)
            4'd0: w_word0 = {1'b0, i_cmd_alt, 5'b0, i_cmd_rs2, i_cmd_rs1, i_cmd_funct3, i_cmd_rd, OP_R};
            4'd1: begin
                if (i_cmd_funct3 == 3'b001 || i_cmd_funct3 == 3'b101)
                    w_word0 = {w_ishamt, i_cmd_rs1, i_cmd_funct3, i_cmd_rd, OP_I};
                else
                    w_word0 = {i_cmd_imm[11:0], i_cmd_rs1, i_cmd_funct3, i_cmd_rd, OP_I};
            end
            4'd2: w_word0 = {i_cmd_imm[11:0], i_cmd_rs1, i_cmd_funct3, i_cmd_rd, OP_LOAD};
            4'd3: w_word0 = {i_cmd_imm[11:5], i_cmd_rs2, i_cmd_rs1, i_cmd_funct3,
                             i_cmd_imm[4:0], OP_STORE};
            4'd4: w_word0 = {i_cmd_imm[12], i_cmd_imm[10:5], i_cmd_rs2, i_cmd_rs1, i_cmd_funct3,
                             i_cmd_imm[4:1], i_cmd_imm[11], OP_BRANCH};
            4'd5: w_word0 = {i_cmd_imm[20], i_cmd_imm[10:1], i_cmd_imm[11], i_cmd_imm[19:12],
                             i_cmd_rd, OP_JAL};
            4'd6: w_word0 = {i_cmd_imm[11:0], i_cmd_rs1, 3'b000, i_cmd_rd, OP_JALR};
            4'd7: w_word0 = {i_cmd_imm[31:12], i_cmd_rd, OP_LUI};
            4'd8: w_word0 = {i_cmd_imm[31:12], i_cmd_rd, OP_AUIPC};
            4'd9: begin
                if (w_li_small) begin
                    w_word0 = {i_cmd_imm[11:0], 5'd0, 3'b000, i_cmd_rd, OP_I};
                end else if (i_cmd_imm[11:0] == 12'd0) begin
                    w_word0 = {i_cmd_imm[31:12], i_cmd_rd, OP_LUI};
                end else begin
                    w_word0  = {w_li_hi, i_cmd_rd, OP_LUI};
                    w_word1  = {i_cmd_imm[11:0], i_cmd_rd, 3'b000, i_cmd_rd, OP_I};
                    w_nwords = 2'd2;
                end
            end
            default: begin
                w_nwords  = 2'd0;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_addr       <= LP_BASE;
            r_wd         <= 32'd0;
            r_ptr        <= LP_BASE;
            r_word_count <= '0;
            r_done       <= 1'b0;
            r_err_op     <= 1'b0;
            r_overflow   <= 1'b0;
            r_pend_wd    <= 32'd0;
            r_pend_last  <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (r_state == ST_DONE)
                r_done <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_illegal) begin
                            r_err_op <= 1'b1;
                            if (i_cmd_last)
                                r_state <= ST_DONE;
                        end else if (w_need > w_free) begin
                            r_overflow <= 1'b1;
                            r_state    <= ST_FULL;
                        end else begin
                            r_we         <= 1'b1;
                            r_addr       <= r_ptr;
                            r_wd         <= w_word0;
                            r_ptr        <= r_ptr + 1'b1;
                            r_word_count <= r_word_count + 1'b1;
                            if (w_nwords == 2'd2) begin
                                r_pend_wd   <= w_word1;
                                r_pend_last <= i_cmd_last;
                                r_state     <= ST_EMIT2;
                            end else if (i_cmd_last) begin
                                r_state <= ST_DONE;
                            end
                        end
                    end
                end
                ST_EMIT2: begin
                    r_we         <= 1'b1;
                    r_addr       <= r_ptr;
                    r_wd         <= r_pend_wd;
                    r_ptr        <= r_ptr + 1'b1;
                    r_word_count <= r_word_count + 1'b1;
                    r_state      <= r_pend_last ? ST_DONE : ST_IDLE;
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign o_cmd_ready  = (r_state == ST_IDLE);
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_addr;
    assign o_imem_wd    = r_wd;
    assign o_word_count = r_word_count;
    assign o_done       = r_done;
    assign o_err_op     = r_err_op;
    assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a full-size instance and a 4-word instance for capacity cases.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld_a = 1'b0;
    logic        vld_b = 1'b0;
    logic [3:0]  op = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic        alt = 1'b0;
    logic [31:0] imm = '0;
    logic        last = 1'b0;

    logic        rdy_a, we_a, done_a, err_a, ovf_a;
    logic [9:0]  addr_a;
    logic [31:0] wd_a;
    logic [10:0] wc_a;

    logic        rdy_b, we_b, done_b, err_b, ovf_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b;
    logic [2:0]  wc_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld_a), .o_cmd_ready(rdy_a),
        .i_cmd_op(op), .i_cmd_rd(rd), .i_cmd_rs1(rs1), .i_cmd_rs2(rs2),
        .i_cmd_funct3(f3), .i_cmd_alt(alt), .i_cmd_imm(imm), .i_cmd_last(last),
        .o_imem_we(we_a), .o_imem_addr(addr_a), .o_imem_wd(wd_a), .o_word_count(wc_a),
        .o_done(done_a), .o_err_op(err_a), .o_overflow(ovf_a)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_cmd_valid(vld_b), .o_cmd_ready(rdy_b),
        .i_cmd_op(op), .i_cmd_rd(rd), .i_cmd_rs1(rs1), .i_cmd_rs2(rs2),
        .i_cmd_funct3(f3), .i_cmd_alt(alt), .i_cmd_imm(imm), .i_cmd_last(last),
        .o_imem_we(we_b), .o_imem_addr(addr_b), .o_imem_wd(wd_b), .o_word_count(wc_b),
        .o_done(done_b), .o_err_op(err_b), .o_overflow(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one command for exactly one rising edge; returns 1ns after that edge.
    task automatic issue(input bit to_b, input logic [3:0] c_op, input logic [4:0] c_rd,
                         input logic [4:0] c_rs1, input logic [4:0] c_rs2, input logic [2:0] c_f3,
                         input logic c_alt, input logic [31:0] c_imm, input logic c_last);
        op = c_op; rd = c_rd; rs1 = c_rs1; rs2 = c_rs2; f3 = c_f3;
        alt = c_alt; imm = c_imm; last = c_last;
        if (to_b) vld_b = 1'b1; else vld_a = 1'b1;
        @(posedge clk); #1;
        vld_a = 1'b0; vld_b = 1'b0; last = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_we",    {31'd0, we_a},   32'd0);
        chk("rst_addr",  {22'd0, addr_a}, 32'd0);
        chk("rst_wd",    wd_a,            32'd0);
        chk("rst_wc",    {21'd0, wc_a},   32'd0);
        chk("rst_flags", {29'd0, done_a, err_a, ovf_a}, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", {31'd0, rdy_a}, 32'd1);

        issue(0, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
        chk("add_we",   {31'd0, we_a},   32'd1);
        chk("add_addr", {22'd0, addr_a}, 32'd0);
        chk("add_wd",   wd_a,            32'h002081B3);
        issue(0, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0, 1'b0);
        chk("sub_addr", {22'd0, addr_a}, 32'd1);
        chk("sub_wd",   wd_a,            32'h402081B3);
        tick();
        chk("pulse_we", {31'd0, we_a},   32'd0);
        chk("wc_2",     {21'd0, wc_a},   32'd2);

        issue(0, 4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF, 1'b0);
        chk("li2_lui_addr", {22'd0, addr_a}, 32'd2);
        chk("li2_lui_wd",   wd_a,            32'h123462B7);
        chk("li2_rdy_low",  {31'd0, rdy_a},  32'd0);
        tick();
        chk("li2_addi_we",   {31'd0, we_a},   32'd1);
        chk("li2_addi_addr", {22'd0, addr_a}, 32'd3);
        chk("li2_addi_wd",   wd_a,            32'hFFF28293);
        chk("li2_rdy_back",  {31'd0, rdy_a},  32'd1);

        issue(0, 4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF, 1'b0);
        chk("li_m1_wd",   wd_a,            32'hFFF00093);
        chk("li_m1_addr", {22'd0, addr_a}, 32'd4);
        chk("li_m1_rdy",  {31'd0, rdy_a},  32'd1);
        issue(0, 4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd8, 1'b0);
        chk("beq_addr", {22'd0, addr_a}, 32'd5);
        chk("beq_wd",   wd_a,            32'h00208463);
        issue(0, 4'd9, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b0);
        chk("li_lui_wd", wd_a, 32'h123453B7);
        chk("li_lui_rdy", {31'd0, rdy_a}, 32'd1);
        issue(0, 4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000800, 1'b0);
        chk("jal_wd", wd_a, 32'h001000EF);
        issue(0, 4'd1, 5'd4, 5'd4, 5'd0, 3'd5, 1'b1, 32'hFFFFFFE3, 1'b0);
        chk("srai_addr", {22'd0, addr_a}, 32'd8);
        chk("srai_wd",   wd_a,            32'h40325213);

        issue(0, 4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd1, 1'b0);
        chk("ill_we",  {31'd0, we_a},  32'd0);
        chk("ill_err", {31'd0, err_a}, 32'd1);
        chk("ill_rdy", {31'd0, rdy_a}, 32'd1);
        chk("ill_wc",  {21'd0, wc_a},  32'd9);

        issue(0, 4'd3, 5'd0, 5'd2, 5'd3, 3'd2, 1'b0, 32'h00000024, 1'b1);
        chk("sw_addr",    {22'd0, addr_a}, 32'd9);
        chk("sw_wd",      wd_a,            32'h02312223);
        chk("sw_done_lo", {31'd0, done_a}, 32'd0);
        chk("sw_rdy",     {31'd0, rdy_a},  32'd0);
        tick();
        chk("sw_done_hi", {31'd0, done_a}, 32'd1);
        chk("sw_rdy_hold", {31'd0, rdy_a}, 32'd0);
        chk("sw_wc",      {21'd0, wc_a},   32'd10);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        issue(0, 4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_we",    {31'd0, we_a},   32'd0);
        chk("mid_rst_addr",  {22'd0, addr_a}, 32'd0);
        chk("mid_rst_wd",    wd_a,            32'd0);
        chk("mid_rst_flags", {29'd0, done_a, err_a, ovf_a}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("post_rst_we", {31'd0, we_a},  32'd0);
        chk("post_rst_wc", {21'd0, wc_a},  32'd0);
        issue(0, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
        chk("post_rst_addr", {22'd0, addr_a}, 32'd0);
        chk("post_rst_wd",   wd_a,            32'h002081B3);

        for (int k = 0; k < 4; k++)
            issue(1, 4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
        chk("fill_addr", {30'd0, addr_b}, 32'd3);
        chk("fill_wd",   wd_b,            32'h00500093);
        chk("fill_wc",   {29'd0, wc_b},   32'd4);
        issue(1, 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b0);
        chk("ovf_we",  {31'd0, we_b},  32'd0);
        chk("ovf_flag", {31'd0, ovf_b}, 32'd1);
        chk("ovf_rdy", {31'd0, rdy_b}, 32'd0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        chk("ovf_cleared", {31'd0, ovf_b}, 32'd0);
        for (int k = 0; k < 3; k++)
            issue(1, 4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
        chk("three_wc", {29'd0, wc_b}, 32'd3);
        issue(1, 4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF, 1'b0);
        chk("li_ovf_we",   {31'd0, we_b},  32'd0);
        chk("li_ovf_flag", {31'd0, ovf_b}, 32'd1);
        chk("li_ovf_rdy",  {31'd0, rdy_b}, 32'd0);
        tick();
        chk("li_ovf_no2", {31'd0, we_b}, 32'd0);
        chk("li_ovf_wc",  {29'd0, wc_b}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
